// File: rtl/demux_pkg.sv
// Shared types and constants for the registered 1:4 demultiplexer.
//   dsel_t        : 2-bit destination channel select
//   SEL_00..SEL_11: channel select encodings
//   NUM_CH        : number of consumer channels
package demux_pkg;

  typedef logic [1:0] dsel_t;

  localparam dsel_t SEL_00 = 2'b00;
  localparam dsel_t SEL_01 = 2'b01;
  localparam dsel_t SEL_10 = 2'b10;
  localparam dsel_t SEL_11 = 2'b11;

  localparam int NUM_CH = 4;

endpackage

// File: rtl/demux_slot.sv
// One-entry output register for a single demux channel, valid/ready on the
// consumer side. The load strobe is pre-qualified by the top (it only fires
// when the slot is empty or draining this cycle).
// Optional per-channel transfer counter under `DEMUX_COUNT_EN`.
//   clk, reset_n : clock, async active-low reset
//   load         : accept din this cycle
//   ready        : consumer accepts the held beat this cycle
//   din          : beat payload
//   dout, valid  : held beat and its valid flag
//   cnt          : accepted-load count, wraps (only with DEMUX_COUNT_EN)
module demux_slot #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             ready,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
`ifdef DEMUX_COUNT_EN
  output logic [CNT_W-1:0] cnt,
`endif
  output logic             valid
);

  if (WIDTH < 1) begin : g_bad_width
    $error("demux_slot: WIDTH must be > 0");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("demux_slot: CNT_W must be > 0");
  end

  // Load wins over drain: a simultaneous drain+load keeps the slot full
  // with the new beat, giving one beat per cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

`ifdef DEMUX_COUNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt <= '0;
    else if (load) cnt <= cnt + 1'b1;
  end
`endif

endmodule

// File: rtl/demux1_4_reg_multibits.sv
// Registered 1:4 demultiplexer: steers one WIDTH-bit valid/ready stream to
// one of four registered consumer channels. No combinational path exists
// from in_valid to in_ready; in_ready depends only on in_sel and the
// selected channel's valid/ready.
// Optional per-channel transfer counters: define DEMUX_COUNT_EN.
//   clk, reset_n          : clock, async active-low reset
//   in_valid/in_ready     : producer handshake
//   in_data, in_sel       : beat payload and destination channel
//   o00..o11              : per-channel registered data
//   out_valid/out_ready   : per-channel consumer handshake (bit k = channel k)
//   cnt00..cnt11          : per-channel load counts (DEMUX_COUNT_EN only)
module demux1_4_reg_multibits
  import demux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  dsel_t             in_sel,
  output logic [WIDTH-1:0]  o00,
  output logic [WIDTH-1:0]  o01,
  output logic [WIDTH-1:0]  o10,
  output logic [WIDTH-1:0]  o11,
`ifdef DEMUX_COUNT_EN
  output logic [CNT_W-1:0]  cnt00,
  output logic [CNT_W-1:0]  cnt01,
  output logic [CNT_W-1:0]  cnt10,
  output logic [CNT_W-1:0]  cnt11,
`endif
  output logic [NUM_CH-1:0] out_valid,
  input  logic [NUM_CH-1:0] out_ready
);

  if (WIDTH < 1) begin : g_bad_width
    $error("demux1_4_reg_multibits: WIDTH must be > 0");
  end

  logic [NUM_CH-1:0]            sel_oh;
  logic [NUM_CH-1:0]            load;
  logic [NUM_CH-1:0][WIDTH-1:0] dout;
  logic                         accept;

  always_comb begin
    sel_oh = '0;
    case (in_sel)
      SEL_00:  sel_oh = 4'b0001;
      SEL_01:  sel_oh = 4'b0010;
      SEL_10:  sel_oh = 4'b0100;
      SEL_11:  sel_oh = 4'b1000;
      default: sel_oh = '0;
    endcase
  end

  // Selected slot can take a beat if empty or draining this cycle.
  assign in_ready = !out_valid[in_sel] || out_ready[in_sel];
  // Gate by in_valid first so an unknown in_sel while idle cannot load.
  assign accept   = in_valid && in_ready;
  assign load     = accept ? sel_oh : '0;

`ifdef DEMUX_COUNT_EN
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  assign cnt00 = cnt[0];
  assign cnt01 = cnt[1];
  assign cnt10 = cnt[2];
  assign cnt11 = cnt[3];
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : easlot
    demux_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load[k]),
      .ready   (out_ready[k]),
      .din     (in_data),
      .dout    (dout[k]),
`ifdef DEMUX_COUNT_EN
      .cnt     (cnt[k]),
`endif
      .valid   (out_valid[k])
    );
  end

  assign o00 = dout[0];
  assign o01 = dout[1];
  assign o10 = dout[2];
  assign o11 = dout[3];

endmodule

// File: tb/tb_demux1_4_reg_multibits.sv
module tb_demux1_4_reg_multibits;

  localparam int WIDTH = 64;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] o00, o01, o10, o11;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] cnt00, cnt01, cnt10, cnt11;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  demux1_4_reg_multibits #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .o00       (o00),
    .o01       (o01),
    .o10       (o10),
    .o11       (o11),
`ifdef DEMUX_COUNT_EN
    .cnt00     (cnt00),
    .cnt01     (cnt01),
    .cnt10     (cnt10),
    .cnt11     (cnt11),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [63:0] d;
    logic [3:0]  rdy;
    logic        exp_rdy;   // in_ready before the edge
    logic [3:0]  exp_vld;   // out_valid after the edge
    int          ch;        // channel whose data is checked after the edge
    logic [63:0] exp_d;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] odata(input int ch);
    case (ch)
      0:       return o00;
      1:       return o01;
      2:       return o10;
      default: return o11;
    endcase
  endfunction

  task automatic drive(input logic v, input logic [1:0] s, input logic [63:0] d, input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  initial begin
    // Idle -> route -> stall -> simultaneous drain/load -> back-to-back.
    vecs[0]  = '{1'b1, 2'd2, 64'hDEAD_BEEF, 4'b0000, 1'b1, 4'b0100, 2, 64'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 2'd2, 64'h0,         4'b0000, 1'b0, 4'b0100, 2, 64'hDEAD_BEEF};
    vecs[2]  = '{1'b0, 2'd0, 64'h0,         4'b0000, 1'b1, 4'b0100, 2, 64'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 2'd0, 64'h11,        4'b0000, 1'b1, 4'b0101, 0, 64'h11};
    vecs[4]  = '{1'b1, 2'd1, 64'h33,        4'b0000, 1'b1, 4'b0111, 1, 64'h33};
    vecs[5]  = '{1'b1, 2'd0, 64'h22,        4'b0011, 1'b1, 4'b0101, 0, 64'h22};
    vecs[6]  = '{1'b0, 2'd2, 64'h0,         4'b0100, 1'b1, 4'b0001, 2, 64'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 2'd0, 64'h44,        4'b0000, 1'b0, 4'b0001, 0, 64'h22};
    vecs[8]  = '{1'b1, 2'd3, 64'h1,         4'b1111, 1'b1, 4'b1000, 3, 64'h1};
    vecs[9]  = '{1'b1, 2'd3, 64'h2,         4'b1111, 1'b1, 4'b1000, 3, 64'h2};
    vecs[10] = '{1'b1, 2'd3, 64'h3,         4'b1111, 1'b1, 4'b1000, 3, 64'h3};
    vecs[11] = '{1'b1, 2'd3, 64'h4,         4'b1111, 1'b1, 4'b1000, 3, 64'h4};
    vecs[12] = '{1'b0, 2'd3, 64'h0,         4'b1111, 1'b1, 4'b0000, 3, 64'h4};

    // Reset with a beat offered: nothing may be captured.
    reset_n = 1'b0;
    drive(1'b1, 2'd1, 64'hA5, 4'b0000);
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {60'd0, out_valid}, 64'd0);
    drive(1'b0, 2'd1, 64'hA5, 4'b0000);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_out_valid", {60'd0, out_valid}, 64'd0);
    check("post_rst_o01", o01, 64'd0);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].sel, vecs[i].d, vecs[i].rdy);
      #1;
      check($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].exp_rdy});
      @(posedge clk); #1;
      check($sformatf("v%0d_out_valid", i), {60'd0, out_valid}, {60'd0, vecs[i].exp_vld});
      check($sformatf("v%0d_data", i), odata(vecs[i].ch), vecs[i].exp_d);
    end

    // Fill channels 00 and 11, then reset between edges.
    @(negedge clk); drive(1'b1, 2'd0, 64'hAA, 4'b0000);
    @(negedge clk); drive(1'b1, 2'd3, 64'hBB, 4'b0000);
    @(negedge clk); drive(1'b0, 2'd0, 64'h0, 4'b0000);
    #1;
    check("pre_async_out_valid", {60'd0, out_valid}, 64'h9);
    check("pre_async_o11", o11, 64'hBB);
    reset_n = 1'b0;
    #1;
    check("async_out_valid", {60'd0, out_valid}, 64'd0);
    check("async_o00", o00, 64'd0);
    check("async_o11", o11, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("after_async_out_valid", {60'd0, out_valid}, 64'd0);

`ifdef DEMUX_COUNT_EN
    // 17 loads on a 4-bit counter wraps to 1.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk); drive(1'b1, 2'd1, 64'(i), 4'b1111);
    end
    @(negedge clk); drive(1'b0, 2'd0, 64'h0, 4'b1111);
    #1;
    check("cnt01_wrap", {60'd0, cnt01}, 64'd1);
    check("cnt00", {60'd0, cnt00}, 64'd0);
    check("cnt10", {60'd0, cnt10}, 64'd0);
    check("cnt11", {60'd0, cnt11}, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1_4_reg_multibits.md
Name: demux1_4_reg_multibits

Overview:
- Registered 1-to-4 demultiplexer. It is the routing counterpart of the 4:1 multibit mux: one WIDTH-bit producer stream is steered to one of four consumer channels.
- Each consumer channel has its own one-entry output register and valid/ready handshake.
- Used in the pipelined datapath to dispatch a result (e.g. ALU/memory value) to one of four downstream consumers without combinational paths from consumer ready to producer data.

Parameters:
- WIDTH, 64, data width in bits; must be > 0 (elaboration-time assertion).
- CNT_W, 16, width of per-channel transfer counters (used only with the optional feature).

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset
- in_valid  input  1  producer presents a beat
- in_ready  output  1  block accepts the beat this cycle
- in_data  input  WIDTH  beat payload
- in_sel  input  2  destination channel; 2'b00→o00, 2'b01→o01, 2'b10→o10, 2'b11→o11
- o00, o01, o10, o11  output  WIDTH each  per-channel registered data
- out_valid  output  4  bit k = channel k holds a beat
- out_ready  input  4  bit k = consumer k accepts this cycle
- cnt00, cnt01, cnt10, cnt11  output  CNT_W each  per-channel accepted-transfer count (present only under DEMUX_COUNT_EN)

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous-to-clk deassert by system): out_valid=4'b0000; o00..o11=0; counters=0. in_ready is combinational and reads 1 during reset, but no beat is captured while reset_n is low.
- Reset mid-operation: all held beats are discarded and not replayed; consumers see out_valid drop in the same cycle reset asserts.
- Per channel k, a 2-state slot: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
- Drain_k = out_valid[k] & out_ready[k].
- Load_k = in_valid & in_ready & (in_sel==k).
- in_ready = !out_valid[in_sel] | out_ready[in_sel]. It is combinational from in_sel, out_valid and out_ready only, never from in_valid.
- Slot transitions:
  - EMPTY & Load → FULL; o_k <= in_data.
  - FULL & Drain & !Load → EMPTY; o_k holds its last value.
  - FULL & Drain & Load → stays FULL; o_k <= in_data (back-to-back, full throughput).
  - FULL & !Drain → stays FULL; o_k stable. Load is impossible because in_ready=0 for that channel.
- Latency: a beat accepted in cycle N appears on o_k with out_valid[k]=1 in cycle N+1.
- Throughput: 1 beat/cycle to any channel whose consumer keeps ready high.
- Independence: non-selected channels drain independently in the same cycle. A stalled channel blocks the input only while in_sel points at it. There is no head-of-line blocking across channels, because the producer may change in_sel.
- in_sel and in_data are sampled only on accepting cycles. When in_valid=0, out_valid and o_k change only by Drain.
- in_valid=1 with in_ready=0 is legal: the producer holds the beat. The block imposes no stability requirement beyond standard valid/ready usage.
- X on in_sel while in_valid=0 must not corrupt state.

Optional Feature:
- Macro: DEMUX_COUNT_EN.
- Defined: ports cnt00..cnt11 exist. cnt_k increments by 1 on each Load_k, wraps from 2^CNT_W-1 to 0 with no saturation or flag, and resets to 0.
- Undefined: counter ports and logic are absent. All other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - typedef logic [1:0] dsel_t.
  - Constants SEL_00=2'b00, SEL_01=2'b01, SEL_10=2'b10, SEL_11=2'b11.
  - Constant NUM_CH=4.
- Sub-module demux_slot #(WIDTH): one-entry register with load/drain/valid and an optional counter, instantiated 4× in a generate loop (easlot). The top contains only select decode and in_ready logic.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1, in_sel=2'b01, in_data=64'hA5 → out_valid=0000, o01=0 after release; no capture.
- Single route: in_sel=2'b10, in_data=64'hDEAD_BEEF, out_ready=0000 → next cycle out_valid=0100 and o10=64'hDEAD_BEEF; in_ready=0 while in_sel=2'b10; in_ready=1 when in_sel=2'b00.
- Back-to-back: out_ready=1111, stream 1,2,3,4 all to sel 2'b11 on consecutive cycles → o11 shows 1,2,3,4 in cycles N+1..N+4; out_valid[3] stays 1 throughout; in_ready never drops.
- Simultaneous: channel 00 FULL with 64'h11, out_ready[0]=1, load 64'h22 to sel 00 in the same cycle → o00=64'h22, out_valid[0]=1; meanwhile channel 01 drains independently to 0.
- Mid-operation reset: channels 00 and 11 FULL, assert reset_n=0 asynchronously between edges → out_valid=0000 immediately, without waiting for a clock edge.
- With DEMUX_COUNT_EN and CNT_W=4: 17 loads to sel 2'b01 → cnt01=1 (wrapped); cnt00, cnt10, cnt11=0.
